// File: rtl/state_report_pkg.sv
// Shared constants and FSM encoding for the AWG status-report transmitter.
package state_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_F = 3'd1,
        ST_CONV_P = 3'd2,
        ST_CONV_A = 3'd3,
        ST_SEND   = 3'd4
    } fsm_state_t;

    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int FRAME_LEN_EOL    = 16;
    localparam int FRAME_LEN_NO_EOL = 14;

    // Each conversion phase is one load cycle plus twelve shift cycles.
    localparam logic [3:0] CONV_LAST_CYC = 4'd12;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/state_report_if.sv
// Byte stream from the status transmitter toward the UART transmit path.
interface state_report_if;
    // A byte transfers on every clk edge where tx_valid && tx_ready. Once
    // tx_valid is high it stays high with tx_data stable until that transfer;
    // tx_ready may be high before tx_valid and never gates tx_valid.
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/state_report_bin2bcd12.sv
// Sequential 12-bit double-dabble: load on start, then twelve shift/add-3 steps.
module bin2bcd12 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] value,
    output logic [15:0] bcd,
    output logic        done
);

    logic [11:0] bin_q;
    logic [3:0]  shift_cnt;
    logic [15:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (start) begin
            bin_q     <= value;
            bcd       <= '0;
            shift_cnt <= 4'd12;
            done      <= 1'b0;
        end else if (shift_cnt != 4'd0) begin
            {bcd, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
            shift_cnt    <= shift_cnt - 4'd1;
            done         <= (shift_cnt == 4'd1);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/state_report.sv
// Snapshots the waveform settings on trigger and streams them as an ASCII
// frame "SdFddddAddPddd[CR LF]" one byte per transfer.
module state_report
    import state_report_pkg::*;
#(
    parameter bit EOL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           trigger,
    input  logic [2:0]     state,
    input  logic [11:0]    state_freq,
    input  logic [3:0]     state_amp,
    input  logic [7:0]     state_phase,
    state_report_if.master tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int         FRAME_LEN = EOL_EN ? FRAME_LEN_EOL : FRAME_LEN_NO_EOL;
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

    fsm_state_t  fsm_state, next_state;
    logic [2:0]  snap_state;
    logic [11:0] snap_freq;
    logic [3:0]  snap_amp;
    logic [7:0]  snap_phase;
    logic [3:0]  cyc_cnt;
    logic [3:0]  byte_idx;
    logic [15:0] freq_bcd;
    logic [11:0] phase_bcd;
    logic [7:0]  amp_bcd;
    logic        done_q;
    logic        send_xfer;
    logic        in_conv;
    logic        conv_start;
    logic        conv_done;
    logic [11:0] conv_value;
    logic [15:0] conv_bcd;
    logic [7:0]  frame_byte;

    assign in_conv    = fsm_state inside {ST_CONV_F, ST_CONV_P, ST_CONV_A};
    assign conv_start = in_conv && (cyc_cnt == 4'd0);
    assign send_xfer  = (fsm_state == ST_SEND) && tx.tx_ready;

    always_comb begin
        conv_value = snap_freq;
        if (fsm_state == ST_CONV_P) conv_value = {4'h0, snap_phase};
        if (fsm_state == ST_CONV_A) conv_value = {8'h00, snap_amp};
    end

    bin2bcd12 u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (conv_value),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_state <= ST_IDLE;
        else        fsm_state <= next_state;
    end

    always_comb begin
        next_state = fsm_state;
        case (fsm_state)
            ST_IDLE:   if (trigger)                    next_state = ST_CONV_F;
            ST_CONV_F: if (cyc_cnt == CONV_LAST_CYC)   next_state = ST_CONV_P;
            ST_CONV_P: if (cyc_cnt == CONV_LAST_CYC)   next_state = ST_CONV_A;
            ST_CONV_A: if (cyc_cnt == CONV_LAST_CYC)   next_state = ST_SEND;
            ST_SEND:   if (send_xfer && byte_idx == LAST_IDX) next_state = ST_IDLE;
            default:                                   next_state = ST_IDLE;
        endcase
    end

    // A conversion result appears one cycle into the following phase, so each
    // field is captured there; amp lands in the first SEND cycle, well before
    // its digits at bytes 8-9 can be reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_state <= '0;
            snap_freq  <= '0;
            snap_amp   <= '0;
            snap_phase <= '0;
            cyc_cnt    <= '0;
            byte_idx   <= '0;
            freq_bcd   <= '0;
            phase_bcd  <= '0;
            amp_bcd    <= '0;
            done_q     <= 1'b0;
        end else begin
            if (fsm_state == ST_IDLE && trigger) begin
                snap_state <= state;
                snap_freq  <= state_freq;
                snap_amp   <= state_amp;
                snap_phase <= state_phase;
            end
            if (!in_conv || next_state != fsm_state) cyc_cnt <= 4'd0;
            else                                     cyc_cnt <= cyc_cnt + 4'd1;
            if (send_xfer) byte_idx <= (byte_idx == LAST_IDX) ? 4'd0 : byte_idx + 4'd1;
            done_q <= send_xfer && (byte_idx == LAST_IDX);
            if (conv_done) begin
                case (fsm_state)
                    ST_CONV_P: freq_bcd  <= conv_bcd;
                    ST_CONV_A: phase_bcd <= conv_bcd[11:0];
                    ST_SEND:   amp_bcd   <= conv_bcd[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            4'd0:  frame_byte = ASCII_S;
            4'd1:  frame_byte = ASCII_ZERO + {5'b0, snap_state};
            4'd2:  frame_byte = ASCII_F;
            4'd3:  frame_byte = ascii_digit(freq_bcd[15:12]);
            4'd4:  frame_byte = ascii_digit(freq_bcd[11:8]);
            4'd5:  frame_byte = ascii_digit(freq_bcd[7:4]);
            4'd6:  frame_byte = ascii_digit(freq_bcd[3:0]);
            4'd7:  frame_byte = ASCII_A;
            4'd8:  frame_byte = ascii_digit(amp_bcd[7:4]);
            4'd9:  frame_byte = ascii_digit(amp_bcd[3:0]);
            4'd10: frame_byte = ASCII_P;
            4'd11: frame_byte = ascii_digit(phase_bcd[11:8]);
            4'd12: frame_byte = ascii_digit(phase_bcd[7:4]);
            4'd13: frame_byte = ascii_digit(phase_bcd[3:0]);
            4'd14: frame_byte = ASCII_CR;
            4'd15: frame_byte = ASCII_LF;
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        busy        = (fsm_state != ST_IDLE);
        frame_done  = done_q;
        tx.tx_valid = (fsm_state == ST_SEND);
        tx.tx_data  = (fsm_state == ST_SEND) ? frame_byte : 8'h00;
    end

endmodule

// File: tb/tb_state_report.sv
// Bench for state_report: one instance with CR LF, one without, shared inputs.
module tb_state_report;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig0 = 1'b0;
    logic        trig1 = 1'b0;
    logic        tx_ready = 1'b0;
    logic [2:0]  st_in = '0;
    logic [11:0] freq_in = '0;
    logic [3:0]  amp_in = '0;
    logic [7:0]  phase_in = '0;
    logic        busy0, busy1, done0, done1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    state_report_if tx0();
    state_report_if tx1();
    assign tx0.tx_ready = tx_ready;
    assign tx1.tx_ready = tx_ready;

    state_report #(.EOL_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .trigger(trig0), .state(st_in), .state_freq(freq_in),
        .state_amp(amp_in), .state_phase(phase_in), .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    state_report #(.EOL_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .trigger(trig1), .state(st_in), .state_freq(freq_in),
        .state_amp(amp_in), .state_phase(phase_in), .tx(tx1), .busy(busy1), .frame_done(done1)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    // drivers
    function automatic logic cur_valid(input bit sel);
        return sel ? tx1.tx_valid : tx0.tx_valid;
    endfunction

    function automatic logic [7:0] cur_data(input bit sel);
        return sel ? tx1.tx_data : tx0.tx_data;
    endfunction

    task automatic set_trig(input bit sel, input logic v);
        if (sel) trig1 = v;
        else     trig0 = v;
    endtask

    task automatic fire(input bit sel);
        set_trig(sel, 1'b1);
        step();
        set_trig(sel, 1'b0);
    endtask

    task automatic drive_values(input int s, input int f, input int a, input int p);
        st_in    = 3'(s);
        freq_in  = 12'(f);
        amp_in   = 4'(a);
        phase_in = 8'(p);
    endtask

    // reference model: the frame as the host should read it
    task automatic build_expected(input int s, input int f, input int a, input int p, input bit eol);
        exp_q.delete();
        exp_q.push_back("S");
        exp_q.push_back(8'(48 + s));
        exp_q.push_back("F");
        for (int div = 1000; div >= 1; div /= 10) exp_q.push_back(8'(48 + (f / div) % 10));
        exp_q.push_back("A");
        for (int div = 10; div >= 1; div /= 10) exp_q.push_back(8'(48 + (a / div) % 10));
        exp_q.push_back("P");
        for (int div = 100; div >= 1; div /= 10) exp_q.push_back(8'(48 + (p / div) % 10));
        if (eol) begin
            exp_q.push_back(8'd13);
            exp_q.push_back(8'd10);
        end
    endtask

    task automatic wait_valid(input bit sel, input int budget, output int steps);
        steps = 0;
        while (!cur_valid(sel) && steps < budget) begin
            step();
            steps++;
        end
    endtask

    // Collects n transferred bytes; optionally randomizes ready and pulses the
    // trigger once when trig_at bytes have been received.
    task automatic recv(input bit sel, input int n, input bit rnd, input int trig_at,
                        output int cycles, output bit stall_bad, output int done_seen);
        bit         prev_stall = 1'b0;
        bit         pulsed = 1'b0;
        logic [7:0] prev_d = '0;
        logic       v;
        logic [7:0] d;
        got_q.delete();
        cycles = 0;
        stall_bad = 1'b0;
        done_seen = 0;
        while (got_q.size() < n && cycles < 2000) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (trig_at >= 0 && !pulsed && got_q.size() == trig_at) begin
                set_trig(sel, 1'b1);
                pulsed = 1'b1;
            end else begin
                set_trig(sel, 1'b0);
            end
            v = cur_valid(sel);
            d = cur_data(sel);
            if (prev_stall && (!v || d !== prev_d)) stall_bad = 1'b1;
            if ((sel ? done1 : done0) === 1'b1) done_seen++;
            if (v && tx_ready) got_q.push_back(d);
            prev_stall = v && !tx_ready;
            prev_d = d;
            cycles++;
            step();
        end
        set_trig(sel, 1'b0);
    endtask

    // tests
    task automatic test_reset();
        do_reset();
        n_checks++; if (tx0.tx_data !== 8'h00) begin n_fails++; $display("FAIL reset_data: got %02h want 00", tx0.tx_data); end
        n_checks++; if (tx0.tx_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", tx0.tx_valid); end
        n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b want 0", done0); end
        n_checks++; if ({tx1.tx_valid, busy1, done1} !== 3'b000) begin n_fails++; $display("FAIL reset_dut1: got %b want 000", {tx1.tx_valid, busy1, done1}); end
    endtask

    task automatic test_basic();
        int lat, cyc, dseen;
        bit stall;
        tx_ready = 1'b1;
        drive_values(3, 1234, 7, 45);
        build_expected(3, 1234, 7, 45, 1'b1);
        fire(0);
        n_checks++; if (busy0 !== 1'b1) begin n_fails++; $display("FAIL basic_busy: got %b want 1", busy0); end
        wait_valid(0, 100, lat);
        n_checks++; if (lat != 39) begin n_fails++; $display("FAIL basic_latency: got %0d want 39", lat); end
        n_checks++; if (tx0.tx_data !== 8'h53) begin n_fails++; $display("FAIL basic_first_byte: got %02h want 53", tx0.tx_data); end
        recv(0, 16, 1'b0, -1, cyc, stall, dseen);
        n_checks++; if (cyc != 16) begin n_fails++; $display("FAIL basic_cycles: got %0d want 16", cyc); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL basic_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (dseen != 0) begin n_fails++; $display("FAIL basic_early_done: got %0d want 0", dseen); end
        n_checks++; if ({done0, busy0, tx0.tx_valid} !== 3'b100) begin n_fails++; $display("FAIL basic_end: done/busy/valid got %b want 100", {done0, busy0, tx0.tx_valid}); end
        step();
        n_checks++; if (done0 !== 1'b0) begin n_fails++; $display("FAIL basic_done_pulse: got %b want 0", done0); end
    endtask

    task automatic test_extremes();
        int s_t[2] = '{7, 0};
        int f_t[2] = '{4095, 0};
        int a_t[2] = '{15, 0};
        int p_t[2] = '{255, 0};
        int lat, cyc, dseen;
        bit stall;
        for (int k = 0; k < 2; k++) begin
            tx_ready = 1'b1;
            drive_values(s_t[k], f_t[k], a_t[k], p_t[k]);
            build_expected(s_t[k], f_t[k], a_t[k], p_t[k], 1'b1);
            fire(0);
            wait_valid(0, 100, lat);
            recv(0, 16, 1'b0, -1, cyc, stall, dseen);
            n_checks++; if (got_q.size() != 16) begin n_fails++; $display("FAIL extreme%0d_len: got %0d want 16", k, got_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL extreme%0d_byte%0d: got %02h want %02h", k, i, got_q[i], exp_q[i]); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int s, f, a, p, lat, cyc, dseen;
        bit stall;
        for (int k = 0; k < 4; k++) begin
            s = $urandom_range(0, 7);
            f = $urandom_range(0, 4095);
            a = $urandom_range(0, 15);
            p = $urandom_range(0, 255);
            drive_values(s, f, a, p);
            build_expected(s, f, a, p, 1'b1);
            tx_ready = 1'($urandom_range(0, 1));
            fire(0);
            drive_values(s + 1, f ^ 12'hA5A, a ^ 4'h9, p ^ 8'h3C);
            wait_valid(0, 100, lat);
            n_checks++; if (lat != 39) begin n_fails++; $display("FAIL bp%0d_latency: got %0d want 39", k, lat); end
            recv(0, 16, 1'b1, -1, cyc, stall, dseen);
            n_checks++; if (stall) begin n_fails++; $display("FAIL bp%0d_stall_hold: got unstable want stable", k); end
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL bp%0d_len: got %0d want %0d", k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL bp%0d_byte%0d: got %02h want %02h", k, i, got_q[i], exp_q[i]); end
            end
            n_checks++; if (done0 !== 1'b1) begin n_fails++; $display("FAIL bp%0d_done: got %b want 1", k, done0); end
            step();
        end
    endtask

    task automatic test_ignored_trigger();
        int lat, cyc, dseen, busy_seen;
        bit stall;
        tx_ready = 1'b1;
        drive_values(5, 321, 4, 99);
        build_expected(5, 321, 4, 99, 1'b1);
        fire(0);
        repeat (10) step();
        drive_values(1, 1, 1, 1);
        fire(0);
        wait_valid(0, 100, lat);
        n_checks++; if (lat != 28) begin n_fails++; $display("FAIL ignore_conv_latency: got %0d want 28", lat); end
        recv(0, 16, 1'b0, 3, cyc, stall, dseen);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL ignore_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL ignore_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        busy_seen = 0;
        repeat (60) begin
            if (busy0 === 1'b1 || tx0.tx_valid === 1'b1) busy_seen++;
            step();
        end
        n_checks++; if (busy_seen != 0) begin n_fails++; $display("FAIL ignore_extra_frame: busy cycles got %0d want 0", busy_seen); end

        // back-to-back: trigger in the frame_done cycle
        drive_values(6, 789, 12, 200);
        build_expected(6, 789, 12, 200, 1'b1);
        fire(0);
        wait_valid(0, 100, lat);
        recv(0, 16, 1'b0, -1, cyc, stall, dseen);
        n_checks++; if (done0 !== 1'b1) begin n_fails++; $display("FAIL b2b_done: got %b want 1", done0); end
        drive_values(2, 55, 3, 9);
        fire(0);
        n_checks++; if (busy0 !== 1'b1) begin n_fails++; $display("FAIL b2b_busy: got %b want 1", busy0); end
        build_expected(2, 55, 3, 9, 1'b1);
        wait_valid(0, 100, lat);
        n_checks++; if (lat != 39) begin n_fails++; $display("FAIL b2b_latency: got %0d want 39", lat); end
        recv(0, 16, 1'b0, -1, cyc, stall, dseen);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL b2b_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat, cyc, dseen, busy_seen;
        bit stall;
        tx_ready = 1'b1;
        drive_values(4, 2048, 9, 128);
        fire(0);
        wait_valid(0, 100, lat);
        recv(0, 6, 1'b0, -1, cyc, stall, dseen);
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({tx0.tx_data, tx0.tx_valid, busy0, done0} !== 11'h0) begin n_fails++; $display("FAIL rstmid_async: data/valid/busy/done got %h want 0", {tx0.tx_data, tx0.tx_valid, busy0, done0}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        busy_seen = 0;
        repeat (50) begin
            if (busy0 === 1'b1 || tx0.tx_valid === 1'b1) busy_seen++;
            step();
        end
        n_checks++; if (busy_seen != 0) begin n_fails++; $display("FAIL rstmid_resume: busy cycles got %0d want 0", busy_seen); end
        tx_ready = 1'b1;
        drive_values(0, 907, 10, 17);
        build_expected(0, 907, 10, 17, 1'b1);
        fire(0);
        wait_valid(0, 100, lat);
        n_checks++; if (lat != 39) begin n_fails++; $display("FAIL rstmid_latency: got %0d want 39", lat); end
        recv(0, 16, 1'b0, -1, cyc, stall, dseen);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL rstmid_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        step();
    endtask

    task automatic test_no_eol();
        int lat, cyc, dseen;
        bit stall;
        tx_ready = 1'b1;
        drive_values(1, 10, 2, 3);
        build_expected(1, 10, 2, 3, 1'b0);
        fire(1);
        n_checks++; if (busy0 !== 1'b0) begin n_fails++; $display("FAIL noeol_other_busy: got %b want 0", busy0); end
        wait_valid(1, 100, lat);
        n_checks++; if (lat != 39) begin n_fails++; $display("FAIL noeol_latency: got %0d want 39", lat); end
        recv(1, 14, 1'b0, -1, cyc, stall, dseen);
        n_checks++; if (cyc != 14) begin n_fails++; $display("FAIL noeol_cycles: got %0d want 14", cyc); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL noeol_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL noeol_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if ({done1, busy1, tx1.tx_valid} !== 3'b100) begin n_fails++; $display("FAIL noeol_end: done/busy/valid got %b want 100", {done1, busy1, tx1.tx_valid}); end
        step();
        n_checks++; if (done1 !== 1'b0) begin n_fails++; $display("FAIL noeol_done_pulse: got %b want 0", done1); end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_ignored_trigger();
        test_reset_mid();
        test_no_eol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
